bcd_modulo_counter: RTL and testbench

//   Two-digit BCD modulo counter for the clock's time fields. One instance
//   per field: seconds and minutes use MODULUS=60, hours use MODULUS=24.

---
 rtl/bcd_modulo_counter_if.sv | 23 ++
 rtl/bcd_modulo_counter.sv | 137 +++++++++++++
 tb/tb_bcd_modulo_counter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_modulo_counter_if.sv
// Request/response bundle for one BCD time field: count/edit requests in,
// digits and wrap pulses out.
interface bcd_modulo_counter_if;
  logic       InTick;
  logic       EditEnable;
  logic       IncBtn;
  logic       DecBtn;
  logic       Clear;
  logic       OutTick;
  logic       BorrowTick;
  logic [3:0] MSD;
  logic [3:0] LSD;

  modport master (
    output InTick, EditEnable, IncBtn, DecBtn, Clear,
    input  OutTick, BorrowTick, MSD, LSD
  );

  modport slave (
    input  InTick, EditEnable, IncBtn, DecBtn, Clear,
    output OutTick, BorrowTick, MSD, LSD
  );
endinterface

// File: rtl/bcd_modulo_counter.sv
// Two-digit BCD modulo counter with tick chaining, inc/dec editing,
// press-and-hold auto-repeat, synchronous clear and borrow output.
module bcd_modulo_counter #(
  parameter int MODULUS       = 60,
  parameter int EDIT_CARRY    = 0,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                 CLK,
  input  logic                 RST,
  bcd_modulo_counter_if.slave  bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX + 1);

  localparam logic [3:0]    TOP_MSD = 4'((MODULUS - 1) / 10);
  localparam logic [3:0]    TOP_LSD = 4'((MODULUS - 1) % 10);
  localparam logic [CW-1:0] DLY_LD  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LD  = CW'(REPEAT_PERIOD - 1);
  localparam logic          CARRY   = (EDIT_CARRY != 0);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    msd_q, msd_d, lsd_q, lsd_d;
  logic          out_tick_q, out_tick_d;
  logic          borrow_tick_q, borrow_tick_d;

  logic one_btn, held, edit_step, tick_step, go_up, at_top, at_zero;

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    cnt_d         = cnt_q;
    msd_d         = msd_q;
    lsd_d         = lsd_q;
    out_tick_d    = 1'b0;
    borrow_tick_d = 1'b0;
    edit_step     = 1'b0;

    one_btn = bus.IncBtn ^ bus.DecBtn;
    // Hold is broken by releasing Dir, pressing the other button or leaving edit.
    held    = bus.EditEnable &
              (dir_q ? (bus.IncBtn & ~bus.DecBtn) : (bus.DecBtn & ~bus.IncBtn));

    if (bus.Clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.EditEnable && one_btn) begin
            edit_step = 1'b1;
            dir_d     = bus.IncBtn;
            cnt_d     = DLY_LD;
            state_d   = DELAY;
          end
        end
        default: begin
          if (!held) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            edit_step = 1'b1;
            cnt_d     = PER_LD;
            state_d   = REPEAT;
          end
        end
      endcase
    end

    tick_step = bus.InTick & ~bus.EditEnable & ~bus.Clear;
    go_up     = edit_step ? dir_d : 1'b1;
    at_top    = (msd_q == TOP_MSD) && (lsd_q == TOP_LSD);
    at_zero   = (msd_q == 4'd0) && (lsd_q == 4'd0);

    if (bus.Clear) begin
      msd_d = 4'd0;
      lsd_d = 4'd0;
    end else if (edit_step || tick_step) begin
      if (go_up) begin
        if (at_top) begin
          msd_d      = 4'd0;
          lsd_d      = 4'd0;
          out_tick_d = tick_step | CARRY;
        end else if (lsd_q == 4'd9) begin
          lsd_d = 4'd0;
          msd_d = msd_q + 4'd1;
        end else begin
          lsd_d = lsd_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          msd_d         = TOP_MSD;
          lsd_d         = TOP_LSD;
          borrow_tick_d = CARRY;
        end else if (lsd_q == 4'd0) begin
          lsd_d = 4'd9;
          msd_d = msd_q - 4'd1;
        end else begin
          lsd_d = lsd_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      cnt_q         <= '0;
      msd_q         <= 4'd0;
      lsd_q         <= 4'd0;
      out_tick_q    <= 1'b0;
      borrow_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      cnt_q         <= cnt_d;
      msd_q         <= msd_d;
      lsd_q         <= lsd_d;
      out_tick_q    <= out_tick_d;
      borrow_tick_q <= borrow_tick_d;
    end
  end

  assign bus.MSD        = msd_q;
  assign bus.LSD        = lsd_q;
  assign bus.OutTick    = out_tick_q;
  assign bus.BorrowTick = borrow_tick_q;

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Directed bench: three field instances (MOD60 silent edit, MOD24, MOD60 edit carry).
module tb_bcd_modulo_counter;
  logic CLK, RST;
  int   n_chk, n_pass;

  bcd_modulo_counter_if i60 ();
  bcd_modulo_counter_if i24 ();
  bcd_modulo_counter_if i60c ();

  bcd_modulo_counter #(.MODULUS(60), .EDIT_CARRY(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2))
    u60 (.CLK(CLK), .RST(RST), .bus(i60));
  bcd_modulo_counter #(.MODULUS(24), .EDIT_CARRY(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2))
    u24 (.CLK(CLK), .RST(RST), .bus(i24));
  bcd_modulo_counter #(.MODULUS(60), .EDIT_CARRY(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2))
    u60c (.CLK(CLK), .RST(RST), .bus(i60c));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    i60.InTick = 0;  i60.EditEnable = 0;  i60.IncBtn = 0;  i60.DecBtn = 0;  i60.Clear = 0;
    i24.InTick = 0;  i24.EditEnable = 0;  i24.IncBtn = 0;  i24.DecBtn = 0;  i24.Clear = 0;
    i60c.InTick = 0; i60c.EditEnable = 0; i60c.IncBtn = 0; i60c.DecBtn = 0; i60c.Clear = 0;
    repeat (2) cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick, i60.BorrowTick} !== 10'd0)
      $display("FAIL reset_60 got=%h want=0", {i60.MSD, i60.LSD, i60.OutTick, i60.BorrowTick});
    else n_pass++;
    n_chk++;
    if ({i24.MSD, i24.LSD, i24.OutTick, i24.BorrowTick} !== 10'd0)
      $display("FAIL reset_24 got=%h want=0", {i24.MSD, i24.LSD, i24.OutTick, i24.BorrowTick});
    else n_pass++;
    n_chk++;
    if ({i60c.MSD, i60c.LSD, i60c.OutTick, i60c.BorrowTick} !== 10'd0)
      $display("FAIL reset_60c got=%h want=0", {i60c.MSD, i60c.LSD, i60c.OutTick, i60c.BorrowTick});
    else n_pass++;
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_count_wrap;
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 59; k++) begin
      i60.InTick = 1'b1;
      cyc();
      if (i60.OutTick !== 1'b0) seen = 1'b1;
    end
    i60.InTick = 1'b0;
    n_chk++;
    if ({seen, i60.MSD, i60.LSD} !== {1'b0, 4'd5, 4'd9})
      $display("FAIL count59 got seen=%b %0d%0d want seen=0 59", seen, i60.MSD, i60.LSD);
    else n_pass++;
    i60.InTick = 1'b1;
    cyc();
    i60.InTick = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== {4'd0, 4'd0, 1'b1})
      $display("FAIL wrap60 got %0d%0d ot=%b want 00 ot=1", i60.MSD, i60.LSD, i60.OutTick);
    else n_pass++;
    cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== {4'd0, 4'd0, 1'b0})
      $display("FAIL wrap60_pulse got %0d%0d ot=%b want 00 ot=0", i60.MSD, i60.LSD, i60.OutTick);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp [3];
    exp[0] = {4'd0, 4'd0, 1'b1};
    exp[1] = {4'd0, 4'd1, 1'b0};
    exp[2] = {4'd0, 4'd2, 1'b0};
    for (int k = 0; k < 23; k++) begin
      i24.InTick = 1'b1;
      cyc();
    end
    i24.InTick = 1'b0;
    n_chk++;
    if ({i24.MSD, i24.LSD} !== {4'd2, 4'd3})
      $display("FAIL count23 got %0d%0d want 23", i24.MSD, i24.LSD);
    else n_pass++;
    i24.InTick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++;
      if ({i24.MSD, i24.LSD, i24.OutTick} !== exp[k])
        $display("FAIL b2b[%0d] got %h want %h", k, {i24.MSD, i24.LSD, i24.OutTick}, exp[k]);
      else n_pass++;
    end
    i24.InTick = 1'b0;
  endtask

  task automatic test_borrow;
    i60.EditEnable = 1'b1; i60c.EditEnable = 1'b1;
    i60.DecBtn = 1'b1;     i60c.DecBtn = 1'b1;
    cyc();
    i60.DecBtn = 1'b0;     i60c.DecBtn = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.BorrowTick} !== {4'd5, 4'd9, 1'b0})
      $display("FAIL borrow_silent got %0d%0d bt=%b want 59 bt=0", i60.MSD, i60.LSD, i60.BorrowTick);
    else n_pass++;
    n_chk++;
    if ({i60c.MSD, i60c.LSD, i60c.BorrowTick} !== {4'd5, 4'd9, 1'b1})
      $display("FAIL borrow_carry got %0d%0d bt=%b want 59 bt=1", i60c.MSD, i60c.LSD, i60c.BorrowTick);
    else n_pass++;
    cyc();
    n_chk++;
    if ({i60c.MSD, i60c.LSD, i60c.BorrowTick} !== {4'd5, 4'd9, 1'b0})
      $display("FAIL borrow_pulse got %0d%0d bt=%b want 59 bt=0", i60c.MSD, i60c.LSD, i60c.BorrowTick);
    else n_pass++;
    i60.IncBtn = 1'b1; i60c.IncBtn = 1'b1;
    cyc();
    i60.IncBtn = 1'b0; i60c.IncBtn = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== {4'd0, 4'd0, 1'b0})
      $display("FAIL editwrap_silent got %0d%0d ot=%b want 00 ot=0", i60.MSD, i60.LSD, i60.OutTick);
    else n_pass++;
    n_chk++;
    if ({i60c.MSD, i60c.LSD, i60c.OutTick} !== {4'd0, 4'd0, 1'b1})
      $display("FAIL editwrap_carry got %0d%0d ot=%b want 00 ot=1", i60c.MSD, i60c.LSD, i60c.OutTick);
    else n_pass++;
    cyc();
    i60.EditEnable = 1'b0; i60c.EditEnable = 1'b0;
  endtask

  task automatic test_bcd_steps;
    for (int k = 0; k < 10; k++) begin
      i60.InTick = 1'b1;
      cyc();
    end
    i60.InTick = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD} !== {4'd1, 4'd0})
      $display("FAIL count10 got %0d%0d want 10", i60.MSD, i60.LSD);
    else n_pass++;
    i60.EditEnable = 1'b1;
    i60.DecBtn = 1'b1;
    cyc();
    i60.DecBtn = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD} !== {4'd0, 4'd9})
      $display("FAIL dec10 got %0d%0d want 09", i60.MSD, i60.LSD);
    else n_pass++;
    cyc();
    i60.IncBtn = 1'b1;
    cyc();
    i60.IncBtn = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD} !== {4'd1, 4'd0})
      $display("FAIL inc09 got %0d%0d want 10", i60.MSD, i60.LSD);
    else n_pass++;
    cyc();
  endtask

  task automatic test_autorepeat;
    logic [7:0] exp [10];
    exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h14, 8'h14};
    i60.IncBtn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_chk++;
      if ({i60.MSD, i60.LSD} !== exp[k])
        $display("FAIL hold[%0d] got %h want %h", k, {i60.MSD, i60.LSD}, exp[k]);
      else n_pass++;
    end
    i60.IncBtn = 1'b0;
    cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD} !== 8'h14)
      $display("FAIL hold_release got %h want 14", {i60.MSD, i60.LSD});
    else n_pass++;
  endtask

  task automatic test_conflicts;
    i60.InTick = 1'b1;
    repeat (3) cyc();
    i60.InTick = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== {8'h14, 1'b0})
      $display("FAIL edit_blocks_tick got %h ot=%b want 14 ot=0", {i60.MSD, i60.LSD}, i60.OutTick);
    else n_pass++;
    i60.IncBtn = 1'b1; i60.DecBtn = 1'b1;
    repeat (3) cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD} !== 8'h14)
      $display("FAIL both_btns got %h want 14", {i60.MSD, i60.LSD});
    else n_pass++;
    i60.DecBtn = 1'b0;
    cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD} !== 8'h15)
      $display("FAIL press_after_both got %h want 15", {i60.MSD, i60.LSD});
    else n_pass++;
    repeat (2) cyc();
    i60.Clear = 1'b1;
    cyc();
    i60.Clear = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick, i60.BorrowTick} !== 10'd0)
      $display("FAIL clear_held got %h want 00", {i60.MSD, i60.LSD});
    else n_pass++;
    cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD} !== 8'h01)
      $display("FAIL clear_to_idle got %h want 01", {i60.MSD, i60.LSD});
    else n_pass++;
    i60.IncBtn = 1'b0; i60.EditEnable = 1'b0;
    cyc();
    i60.InTick = 1'b1; i60.Clear = 1'b1;
    cyc();
    i60.InTick = 1'b0; i60.Clear = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== 9'd0)
      $display("FAIL clear_over_tick got %h ot=%b want 00 ot=0", {i60.MSD, i60.LSD}, i60.OutTick);
    else n_pass++;
  endtask

  task automatic test_rst_hold;
    for (int k = 0; k < 35; k++) begin
      i60.InTick = 1'b1;
      cyc();
    end
    i60.InTick = 1'b0;
    n_chk++;
    if ({i60.MSD, i60.LSD} !== 8'h35)
      $display("FAIL count35 got %h want 35", {i60.MSD, i60.LSD});
    else n_pass++;
    i60.EditEnable = 1'b1; i60.IncBtn = 1'b1;
    repeat (5) cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD} !== 8'h37)
      $display("FAIL repeat37 got %h want 37", {i60.MSD, i60.LSD});
    else n_pass++;
    cyc();
    #3;
    RST = 1'b1;
    #1;
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick, i60.BorrowTick} !== 10'd0)
      $display("FAIL async_rst got %h want 0", {i60.MSD, i60.LSD, i60.OutTick, i60.BorrowTick});
    else n_pass++;
    cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== 9'd0)
      $display("FAIL rst_hold got %h want 0", {i60.MSD, i60.LSD, i60.OutTick});
    else n_pass++;
    RST = 1'b0;
    cyc();
    n_chk++;
    if ({i60.MSD, i60.LSD, i60.OutTick} !== {8'h01, 1'b0})
      $display("FAIL post_rst_step got %h ot=%b want 01 ot=0", {i60.MSD, i60.LSD}, i60.OutTick);
    else n_pass++;
    i60.IncBtn = 1'b0; i60.EditEnable = 1'b0;
    cyc();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_count_wrap();
    test_back_to_back();
    test_borrow();
    test_bcd_steps();
    test_autorepeat();
    test_conflicts();
    test_rst_hold();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
